// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-side bundle for the forwarding/hazard controller: ID-stage info in, EX mux selects and stall/bubble out.
// Perf counter outputs exist only when FWD_HAZARD_PERF_EN is defined.
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
);
  logic                  hold;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic [SEL_W-1:0]      fwd_a_sel;
  logic [SEL_W-1:0]      fwd_b_sel;
  logic                  stall;
  logic                  bubble;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]           perf_stall_cnt;
  logic [31:0]           perf_fwd_ex_cnt;
  logic [31:0]           perf_fwd_wb_cnt;

  modport master (
    output hold, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    input  fwd_a_sel, fwd_b_sel, stall, bubble,
           perf_stall_cnt, perf_fwd_ex_cnt, perf_fwd_wb_cnt
  );
  modport slave (
    input  hold, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    output fwd_a_sel, fwd_b_sel, stall, bubble,
           perf_stall_cnt, perf_fwd_ex_cnt, perf_fwd_wb_cnt
  );
`else
  modport master (
    output hold, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    input  fwd_a_sel, fwd_b_sel, stall, bubble
  );
  modport slave (
    input  hold, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    output fwd_a_sel, fwd_b_sel, stall, bubble
  );
`endif
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use stall/bubble control for a 5-stage RISC-V pipeline.
// Optional perf counters are enabled by defining FWD_HAZARD_PERF_EN.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input logic              clk,
  input logic              reset_n,
  fwd_hazard_ctrl_if.slave bus
);

  localparam logic [SEL_W-1:0] SEL_RF = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EX = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_WB = SEL_W'(2);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regWrite;
    logic                  memRead;
  } shadow_t;

  shadow_t          r_ex, r_mem, r_wb;
  shadow_t          w_idShadow;
  logic [SEL_W-1:0] r_selA, r_selB;
  logic [SEL_W-1:0] w_selA, w_selB;
  logic             w_stall, w_bubble;
  logic             w_unusedWb;

  // Younger producer (EX) is checked first so it shadows an older write to the same register in MEM.
  function automatic logic [SEL_W-1:0] pickSel(
    input logic                  useRs,
    input logic [REG_ADDR_W-1:0] rs,
    input shadow_t               ex,
    input shadow_t               mem
  );
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    if (useRs && (rs != '0)) begin
      if (ex.valid && ex.regWrite && (ex.rd == rs)) begin
        sel = SEL_EX;
      end else if (mem.valid && mem.regWrite && (mem.rd == rs)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  assign w_selA = pickSel(bus.id_use_rs1, bus.id_rs1, r_ex, r_mem);
  assign w_selB = pickSel(bus.id_use_rs2, bus.id_rs2, r_ex, r_mem);

  assign w_idShadow = '{valid:    bus.id_valid,
                        rd:       bus.id_rd,
                        regWrite: bus.id_reg_write,
                        memRead:  bus.id_mem_read};

  assign w_stall = bus.id_valid & r_ex.valid & r_ex.memRead & r_ex.regWrite
                 & (r_ex.rd != '0)
                 & ((bus.id_use_rs1 & (bus.id_rs1 == r_ex.rd)) |
                    (bus.id_use_rs2 & (bus.id_rs2 == r_ex.rd)))
                 & ~bus.flush;

  assign w_bubble = (w_stall | bus.flush) & ~bus.hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex   <= '0;
      r_mem  <= '0;
      r_wb   <= '0;
      r_selA <= SEL_RF;
      r_selB <= SEL_RF;
    end else if (!bus.hold) begin
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_bubble) begin
        r_ex.valid <= 1'b0;
        r_selA     <= SEL_RF;
        r_selB     <= SEL_RF;
      end else begin
        r_ex   <= w_idShadow;
        r_selA <= w_selA;
        r_selB <= w_selB;
      end
    end
  end

  // The WB shadow mirrors the pipeline but feeds no decision here.
  assign w_unusedWb = ^r_wb;

  assign bus.fwd_a_sel = r_selA;
  assign bus.fwd_b_sel = r_selB;
  assign bus.stall     = w_stall;
  assign bus.bubble    = w_bubble;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] r_perfStallCnt, r_perfFwdExCnt, r_perfFwdWbCnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perfStallCnt <= '0;
      r_perfFwdExCnt <= '0;
      r_perfFwdWbCnt <= '0;
    end else if (!bus.hold) begin
      if (w_stall) begin
        r_perfStallCnt <= r_perfStallCnt + 32'd1;
      end
      if (!w_bubble && ((w_selA == SEL_EX) || (w_selB == SEL_EX))) begin
        r_perfFwdExCnt <= r_perfFwdExCnt + 32'd1;
      end
      if (!w_bubble && ((w_selA == SEL_WB) || (w_selB == SEL_WB))) begin
        r_perfFwdWbCnt <= r_perfFwdWbCnt + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cnt  = r_perfStallCnt;
  assign bus.perf_fwd_ex_cnt = r_perfFwdExCnt;
  assign bus.perf_fwd_wb_cnt = r_perfFwdWbCnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: the driver pushes expectations from an in-flight instruction
// model; a negedge monitor pops and compares. Perf counters are checked when FWD_HAZARD_PERF_EN is defined.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .SEL_W(2)) intf ();

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .SEL_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (intf.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    bit       rw;
    bit       mr;
    bit [4:0] rd;
  } instr_t;

  typedef struct {
    bit          stall;
    bit          bubble;
    bit [1:0]    selA;
    bit [1:0]    selB;
    bit [31:0]   pStall;
    bit [31:0]   pEx;
    bit [31:0]   pWb;
  } exp_t;

  // Model: in-flight instructions, index 0 is the one in EX, index 1 the one in MEM.
  instr_t      pipe[$];
  exp_t        sbQ[$];
  bit [1:0]    mSelA, mSelB;
  bit [31:0]   mPerfStall, mPerfEx, mPerfWb;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] modelSel(input bit useRs, input bit [4:0] rs);
    if (!useRs || rs == 5'd0) return 2'b00;
    for (int d = 0; d < pipe.size() && d < 2; d++) begin
      if (pipe[d].valid && pipe[d].rw && pipe[d].rd == rs) return (d == 0) ? 2'b01 : 2'b10;
    end
    return 2'b00;
  endfunction

  function automatic bit modelStall();
    instr_t p;
    if (pipe.size() == 0) return 1'b0;
    p = pipe[0];
    if (!(intf.id_valid && p.valid && p.mr && p.rw && p.rd != 5'd0)) return 1'b0;
    if (intf.flush) return 1'b0;
    return (intf.id_use_rs1 && intf.id_rs1 == p.rd) || (intf.id_use_rs2 && intf.id_rs2 == p.rd);
  endfunction

  function automatic void modelReset();
    pipe.delete();
    mSelA = 2'b00;
    mSelB = 2'b00;
    mPerfStall = 0;
    mPerfEx = 0;
    mPerfWb = 0;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT saw at that edge.
  function automatic void modelEdge();
    bit st, bub;
    bit [1:0] a, b;
    instr_t nop, cur;
    if (intf.hold) return;
    st  = modelStall();
    bub = st || intf.flush;
    if (st) mPerfStall++;
    nop = '{valid: 1'b0, rw: 1'b0, mr: 1'b0, rd: 5'd0};
    if (bub) begin
      pipe.push_front(nop);
      mSelA = 2'b00;
      mSelB = 2'b00;
    end else begin
      a = modelSel(intf.id_use_rs1, intf.id_rs1);
      b = modelSel(intf.id_use_rs2, intf.id_rs2);
      if (a == 2'b01 || b == 2'b01) mPerfEx++;
      if (a == 2'b10 || b == 2'b10) mPerfWb++;
      cur = '{valid: intf.id_valid, rw: intf.id_reg_write, mr: intf.id_mem_read, rd: intf.id_rd};
      pipe.push_front(cur);
      mSelA = a;
      mSelB = b;
    end
    while (pipe.size() > 2) void'(pipe.pop_back());
  endfunction

  task automatic setIdle();
    intf.hold = 0; intf.flush = 0; intf.id_valid = 0;
    intf.id_rs1 = 0; intf.id_rs2 = 0; intf.id_use_rs1 = 0; intf.id_use_rs2 = 0;
    intf.id_rd = 0; intf.id_reg_write = 0; intf.id_mem_read = 0;
  endtask

  task automatic applyStimulus(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                               input bit u1, input bit u2, input bit [4:0] rd,
                               input bit rw, input bit mr, input bit fl, input bit hd);
    exp_t e;
    @(posedge clk);
    #2;
    modelEdge();
    intf.id_valid = v; intf.id_rs1 = rs1; intf.id_rs2 = rs2;
    intf.id_use_rs1 = u1; intf.id_use_rs2 = u2; intf.id_rd = rd;
    intf.id_reg_write = rw; intf.id_mem_read = mr; intf.flush = fl; intf.hold = hd;
    e.stall  = modelStall();
    e.bubble = (e.stall || fl) && !hd;
    e.selA   = mSelA;
    e.selB   = mSelB;
    e.pStall = mPerfStall;
    e.pEx    = mPerfEx;
    e.pWb    = mPerfWb;
    sbQ.push_back(e);
  endtask

  // Monitor: mid-cycle, compare everything the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("stall",  intf.stall,     e.stall);
        checkOutput("bubble", intf.bubble,    e.bubble);
        checkOutput("sel_a",  intf.fwd_a_sel, e.selA);
        checkOutput("sel_b",  intf.fwd_b_sel, e.selB);
`ifdef FWD_HAZARD_PERF_EN
        checkOutput("perf_stall", intf.perf_stall_cnt,  e.pStall);
        checkOutput("perf_ex",    intf.perf_fwd_ex_cnt, e.pEx);
        checkOutput("perf_wb",    intf.perf_fwd_wb_cnt, e.pWb);
`endif
      end
    end
  end

  initial begin
    setIdle();
    modelReset();
    #3;
    checkOutput("rst_sel_a", intf.fwd_a_sel, 2'b00);
    checkOutput("rst_sel_b", intf.fwd_b_sel, 2'b00);
    checkOutput("rst_stall", intf.stall, 1'b0);
    checkOutput("rst_bubble", intf.bubble, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // NOPs, back-to-back ALU, distance-2, younger-wins
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    applyStimulus(1, 5, 3, 1, 1, 6, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 10, 1, 0, 0, 0);
    applyStimulus(1, 4, 6, 1, 1, 7, 1, 0, 0, 0);
    applyStimulus(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    applyStimulus(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    applyStimulus(1, 4, 5, 1, 1, 7, 1, 0, 0, 0);
    // load-use, x0, flush over a load-use, hold during a pending forward
    applyStimulus(1, 1, 0, 1, 0, 8, 1, 1, 0, 0);
    applyStimulus(1, 8, 8, 1, 1, 9, 1, 0, 0, 0);
    applyStimulus(1, 8, 8, 1, 1, 9, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 3, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 8, 1, 1, 0, 0);
    applyStimulus(1, 8, 2, 1, 1, 9, 1, 0, 1, 0);
    applyStimulus(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    repeat (4) applyStimulus(1, 5, 3, 1, 1, 6, 1, 0, 0, 1);
    applyStimulus(1, 5, 3, 1, 1, 6, 1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset while a load-use stall is being asserted
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 8, 1, 1, 0, 0);
    applyStimulus(1, 8, 8, 1, 1, 9, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    checkOutput("pre_rst_stall", intf.stall, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_stall", intf.stall, 1'b0);
    checkOutput("async_rst_bubble", intf.bubble, 1'b0);
    checkOutput("async_rst_sel_a", intf.fwd_a_sel, 2'b00);
    checkOutput("async_rst_sel_b", intf.fwd_b_sel, 2'b00);
    setIdle();
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(1, 8, 8, 1, 1, 9, 1, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    repeat (3) @(negedge clk);
    #1;
    checkOutput("sb_drain", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
